// File: rtl/rvv_vd_collector.sv
// rvv_vd_collector
//   Receive end of the vector ALU lane-result interface. It collects per-lane
//   slices into a copy of the old destination register, applying the v0 mask
//   and the tail rule (elements >= vl keep their old value). It then issues a
//   single one-cycle VLEN-bit writeback to the vector register file.
//
// Optional feature macro: RVV_VD_COLLECT_CHK_EN
//   When defined, a per-slice "written" bitmap flags a slice position that is
//   written twice in one operation, including a same-cycle lane collision.
//   The flag is raised on err. Data behaviour is unchanged: the last writer
//   wins.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        begin an operation (sampled only in IDLE)
//   vd_old       prior destination contents, captured at start
//   mask_in      v0 mask bits, captured at start
//   instr_mask   1 = masked instruction, captured at start
//   vsew         element width code (SEW = 8 << vsew), captured at start
//   vl           active vector length, captured at start
//   lane_vd      lane i result in [64i+63:64i]; only the low W bits are used
//   lane_index   lane i bit offset in [10i+9:10i]
//   lane_valid   lane i slice valid this cycle
//   alu_done     ALU has issued its last slice
//   vd_out       assembled register, valid while wr_en = 1
//   wr_en, done  one-cycle write strobe / completion pulse
//   busy         high in COLLECT and WRITE
//   err          sticky error flag, cleared by start or reset
module rvv_vd_collector #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [VLEN-1:0]                 vd_old,
    input  logic [VLEN-1:0]                 mask_in,
    input  logic                            instr_mask,
    input  logic [2:0]                      vsew,
    input  logic [10:0]                     vl,
    input  logic [64*(1<<NB_LANES)-1:0]     lane_vd,
    input  logic [10*(1<<NB_LANES)-1:0]     lane_index,
    input  logic [(1<<NB_LANES)-1:0]        lane_valid,
    input  logic                            alu_done,
    output logic [VLEN-1:0]                 vd_out,
    output logic                            wr_en,
    output logic                            done,
    output logic                            busy,
    output logic                            err
);

    localparam int W     = 1 << LANE_WIDTH;
    localparam int L     = 1 << NB_LANES;
    localparam int NSLOT = VLEN / W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [VLEN-1:0]   buf_q, buf_d;
    logic [VLEN-1:0]   mask_q, mask_d;
    logic              instr_mask_q, instr_mask_d;
    logic [2:0]        vsew_q, vsew_d;
    logic [10:0]       vl_q, vl_d;
    logic              err_q, err_d;
    logic [VLEN-1:0]   vd_out_q, vd_out_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
`ifdef RVV_VD_COLLECT_CHK_EN
    logic [NSLOT-1:0]  written_q, written_d;
`endif

    // Per-lane decode temporaries, rewritten for every lane in the loop below.
    logic [9:0]        idx_s;
    logic [9:0]        elem_s;
    logic [9:0]        slot_s;
    logic              oor_s;
    logic              tail_s;
    logic              moff_s;
    logic              accept_s;

    // Only the low W bits of each lane word carry data.
    logic              lane_vd_unused_s;
    assign lane_vd_unused_s = ^lane_vd;

    // Next-state, buffer assembly and output computation.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        mask_d       = mask_q;
        instr_mask_d = instr_mask_q;
        vsew_d       = vsew_q;
        vl_d         = vl_q;
        err_d        = err_q;
        vd_out_d     = vd_out_q;
        wr_en_d      = 1'b0;
        done_d       = 1'b0;
`ifdef RVV_VD_COLLECT_CHK_EN
        written_d    = written_q;
`endif
        idx_s        = 10'd0;
        elem_s       = 10'd0;
        slot_s       = 10'd0;
        oor_s        = 1'b0;
        tail_s       = 1'b0;
        moff_s       = 1'b0;
        accept_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    buf_d        = vd_old;
                    mask_d       = mask_in;
                    instr_mask_d = instr_mask;
                    vsew_d       = vsew;
                    vl_d         = vl;
                    err_d        = 1'b0;
`ifdef RVV_VD_COLLECT_CHK_EN
                    written_d    = {NSLOT{1'b0}};
`endif
                    state_d      = S_COLLECT;
                end else begin
                    state_d      = S_IDLE;
                end
            end
            S_COLLECT: begin
                // Ascending lane order: a higher lane overwrites a lower one
                // targeting the same slice in the same cycle.
                for (int i = 0; i < L; i++) begin
                    idx_s  = lane_index[10*i +: 10];
                    // Element number: 4-bit shift amount avoids wrap for vsew >= 5.
                    elem_s = idx_s >> ({1'b0, vsew_q} + 4'd3);
                    slot_s = idx_s >> LANE_WIDTH;
                    oor_s  = (({1'b0, idx_s} + 11'(W)) > 11'(VLEN)) ||
                             (idx_s[LANE_WIDTH-1:0] != {LANE_WIDTH{1'b0}});
                    tail_s = ({1'b0, elem_s} >= vl_q);
                    moff_s = instr_mask_q &&
                             ~|(mask_q & ({{(VLEN-1){1'b0}}, 1'b1} << elem_s));
                    accept_s = lane_valid[i] && !oor_s && !tail_s && !moff_s;
                    if (lane_valid[i] && oor_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_d;
                    end
                    for (int s = 0; s < NSLOT; s++) begin
                        if (accept_s && (slot_s == 10'(s))) begin
                            buf_d[s*W +: W] = lane_vd[64*i +: W];
`ifdef RVV_VD_COLLECT_CHK_EN
                            if (written_d[s]) begin
                                err_d = 1'b1;
                            end else begin
                                err_d = err_d;
                            end
                            written_d[s] = 1'b1;
`endif
                        end else begin
                            buf_d[s*W +: W] = buf_d[s*W +: W];
                        end
                    end
                end
                if (alu_done) begin
                    // Slices of the alu_done cycle are already merged in buf_d.
                    state_d  = S_WRITE;
                    vd_out_d = buf_d;
                    wr_en_d  = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d  = S_COLLECT;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= {VLEN{1'b0}};
            mask_q       <= {VLEN{1'b0}};
            instr_mask_q <= 1'b0;
            vsew_q       <= 3'd0;
            vl_q         <= 11'd0;
            err_q        <= 1'b0;
            vd_out_q     <= {VLEN{1'b0}};
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RVV_VD_COLLECT_CHK_EN
            written_q    <= {NSLOT{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            mask_q       <= mask_d;
            instr_mask_q <= instr_mask_d;
            vsew_q       <= vsew_d;
            vl_q         <= vl_d;
            err_q        <= err_d;
            vd_out_q     <= vd_out_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef RVV_VD_COLLECT_CHK_EN
            written_q    <= written_d;
`endif
        end
    end

    assign vd_out = vd_out_q;
    assign wr_en  = wr_en_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Self-checking bench for rvv_vd_collector (VLEN=128, W=8, two lanes).
// A behavioural model computes the expected register from element/mask/tail
// arithmetic; directed scenarios additionally check fixed constants.
module tb_rvv_vd_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] vd_old;
    logic [127:0] mask_in;
    logic         instr_mask;
    logic [2:0]   vsew;
    logic [10:0]  vl;
    logic [127:0] lane_vd;
    logic [19:0]  lane_index;
    logic [1:0]   lane_valid;
    logic         alu_done;
    logic [127:0] vd_out;
    logic         wr_en;
    logic         done;
    logic         busy;
    logic         err;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state
    logic [127:0] m_buf;
    logic [127:0] m_mask;
    bit           m_im;
    int           m_vsew;
    int           m_vl;
    bit           m_err = 1'b0;
`ifdef RVV_VD_COLLECT_CHK_EN
    bit           m_written [16];
`endif

    rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .vd_old(vd_old),
        .mask_in(mask_in), .instr_mask(instr_mask), .vsew(vsew), .vl(vl),
        .lane_vd(lane_vd), .lane_index(lane_index), .lane_valid(lane_valid),
        .alu_done(alu_done), .vd_out(vd_out), .wr_en(wr_en), .done(done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec-level effect of one slice on the model.
    task automatic model_slice(input int idx, input logic [7:0] d);
        int elem;
        if (idx + 8 > 128 || idx % 8 != 0) begin
            m_err = 1'b1;
            return;
        end
        elem = idx / (8 << m_vsew);
        if (elem >= m_vl) return;
        if (m_im && !m_mask[elem]) return;
`ifdef RVV_VD_COLLECT_CHK_EN
        if (m_written[idx/8]) m_err = 1'b1;
        m_written[idx/8] = 1'b1;
`endif
        m_buf[idx +: 8] = d;
    endtask

    task automatic op_start(input logic [127:0] old, input logic [127:0] msk, input bit im,
                            input int sew, input int vlen_a);
        start = 1'b1; vd_old = old; mask_in = msk; instr_mask = im;
        vsew = 3'(sew); vl = 11'(vlen_a);
        // Lane inputs and alu_done in IDLE must be ignored.
        lane_valid = 2'($urandom_range(0, 3));
        lane_index = 20'($urandom);
        lane_vd = {$urandom, $urandom, $urandom, $urandom};
        alu_done = 1'($urandom_range(0, 1));
        m_buf = old; m_mask = msk; m_im = im; m_vsew = sew; m_vl = vlen_a; m_err = 1'b0;
`ifdef RVV_VD_COLLECT_CHK_EN
        for (int k = 0; k < 16; k++) m_written[k] = 1'b0;
`endif
        @(negedge clk);
        start = 1'b0; lane_valid = 2'b00; alu_done = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("err_cleared", err, 1'b0);
    endtask

    task automatic op_cycle(input bit v0, input int i0, input logic [63:0] d0,
                            input bit v1, input int i1, input logic [63:0] d1, input bit last);
        lane_valid = {v1, v0};
        lane_index = {10'(i1), 10'(i0)};
        lane_vd = {d1, d0};
        alu_done = last;
        // start while busy is ignored; so is a changing vd_old.
        start = 1'($urandom_range(0, 1));
        vd_old = {$urandom, $urandom, $urandom, $urandom};
        if (v0) model_slice(i0, d0[7:0]);
        if (v1) model_slice(i1, d1[7:0]);
        @(negedge clk);
        if (!last) check_eq("no_early_wr", wr_en, 1'b0);
    endtask

    task automatic op_finish();
        check_eq("wr_en", wr_en, 1'b1);
        check_eq("done", done, 1'b1);
        check_eq("busy_wr", busy, 1'b1);
        check_eq("vd_out", vd_out, m_buf);
        check_eq("err", err, m_err);
        lane_valid = 2'b00; alu_done = 1'b0; start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check_eq("wr_en_low", wr_en, 1'b0);
        check_eq("done_low", done, 1'b0);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("err_hold", err, m_err);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int rnd_idx();
        if ($urandom_range(0, 3) != 0) return $urandom_range(0, 15) * 8;
        return $urandom_range(0, 1023);
    endfunction

    initial begin
        logic [127:0] ff_v;
        reset = 1'b1; start = 1'b0; vd_old = '0; mask_in = '0; instr_mask = 1'b0;
        vsew = 3'd0; vl = 11'd0; lane_vd = '0; lane_index = '0; lane_valid = 2'b00;
        alu_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_vd_out", vd_out, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Unmasked
        op_start(128'd0, 128'd0, 1'b0, 0, 16);
        op_cycle(1'b1, 0, 64'h11, 1'b1, 8, 64'h22, 1'b0);
        op_cycle(1'b1, 16, 64'h33, 1'b0, 0, 64'h0, 1'b1);
        check_eq("unmasked_const", vd_out, 128'h332211);
        op_finish();

        // Masked
        ff_v = {128{1'b1}};
        op_start(ff_v, 128'h5, 1'b1, 0, 16);
        op_cycle(1'b1, 0, 64'hAA, 1'b1, 8, 64'hAA, 1'b0);
        op_cycle(1'b1, 16, 64'hAA, 1'b1, 24, 64'hAA, 1'b1);
        check_eq("masked_const", vd_out, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hFFAAFFAA});
        op_finish();

        // Tail
        op_start(128'd0, 128'd0, 1'b0, 0, 2);
        op_cycle(1'b1, 0, 64'h77, 1'b1, 8, 64'h77, 1'b0);
        op_cycle(1'b1, 16, 64'h77, 1'b1, 24, 64'h77, 1'b1);
        check_eq("tail_const", vd_out, 128'h7777);
        check_eq("tail_err", err, 1'b0);
        op_finish();

        // SEW16 spanning
        op_start(128'd0, 128'h1, 1'b1, 1, 16);
        op_cycle(1'b1, 0, 64'h34, 1'b1, 8, 64'h12, 1'b0);
        op_cycle(1'b1, 16, 64'h99, 1'b0, 0, 64'h0, 1'b1);
        check_eq("sew16_const", vd_out, 128'h1234);
        op_finish();

        // Out-of-range slice plus an in-range one
        op_start(128'd0, 128'd0, 1'b0, 0, 16);
        op_cycle(1'b1, 128, 64'h55, 1'b1, 8, 64'h66, 1'b1);
        check_eq("oor_err", err, 1'b1);
        check_eq("oor_data", vd_out, 128'h6600);
        op_finish();
        check_eq("oor_sticky", err, 1'b1);
        @(negedge clk);
        check_eq("oor_sticky2", err, 1'b1);

        // Same position twice in separate cycles
        op_start(128'd0, 128'd0, 1'b0, 0, 16);
        op_cycle(1'b1, 8, 64'h11, 1'b0, 0, 64'h0, 1'b0);
        op_cycle(1'b1, 8, 64'h22, 1'b0, 0, 64'h0, 1'b1);
        check_eq("dup_byte1", vd_out[15:8], 128'h22);
`ifdef RVV_VD_COLLECT_CHK_EN
        check_eq("dup_err", err, 1'b1);
`else
        check_eq("dup_err", err, 1'b0);
`endif
        op_finish();

        // Same-cycle collision: lane 1 wins
        op_start(128'd0, 128'd0, 1'b0, 0, 16);
        op_cycle(1'b1, 40, 64'hC1, 1'b1, 40, 64'hC2, 1'b1);
        check_eq("collide_data", vd_out, 128'hC2 << 40);
        op_finish();

        // Reset during COLLECT abandons the operation
        op_start(128'd0, 128'd0, 1'b0, 0, 16);
        op_cycle(1'b1, 0, 64'h5A, 1'b0, 0, 64'h0, 1'b0);
        reset = 1'b1; lane_valid = 2'b00; start = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_wr", wr_en, 1'b0);
        reset = 1'b0; alu_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_mid_no_wr", wr_en, 1'b0);
            check_eq("idle_done_ignored", busy, 1'b0);
        end
        alu_done = 1'b0;

        // Randomized operations against the model
        for (int n = 0; n < 60; n++) begin
            int ncyc;
            int vlr;
            vlr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 20);
            op_start({$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)), $urandom_range(0, 7), vlr);
            ncyc = $urandom_range(1, 6);
            for (int c = 0; c < ncyc; c++) begin
                int i0;
                int i1;
                i0 = rnd_idx();
                i1 = ($urandom_range(0, 4) == 0) ? i0 : rnd_idx();
                op_cycle(1'($urandom_range(0, 1)), i0, rnd64(),
                         1'($urandom_range(0, 1)), i1, rnd64(), c == ncyc - 1);
            end
            op_finish();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rvv_vd_collector.md
Name: rvv_vd_collector

Overview:
- Receive end of the vector ALU lane-result interface: accepts per-lane slices (data, bit index, valid) and the ALU done strobe, then assembles the full destination vector register.
- Applies the v0 mask and the tail rule (elements >= vl keep their old value), then issues a single one-cycle writeback of VLEN bits to the vector register file.
- Sits between the lane ALU array and the vector register file write port in the RVV coprocessor.

Parameters:
- VLEN, 128: vector register width in bits (<= 1023).
- LANE_WIDTH, 3: log2 of the slice width; slice W = 1<<LANE_WIDTH bits.
- NB_LANES, 1: log2 of the lane count; lanes L = 1<<NB_LANES, with L <= 8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- vd_old  in  VLEN  prior destination contents, captured at start.
- mask_in  in  VLEN  v0 mask bits, captured at start.
- instr_mask  in  1  1 = masked instruction, so mask_in applies; captured at start.
- vsew  in  3  element width code, SEW = 8<<vsew; captured at start.
- vl  in  11  active vector length; captured at start.
- lane_vd  in  64*L  lane i result in bits [64i+63:64i]; only the low W bits are used.
- lane_index  in  10*L  lane i bit offset of its slice.
- lane_valid  in  L  lane i slice valid this cycle.
- alu_done  in  1  ALU has issued its last slice.
- vd_out  out  VLEN  assembled register, valid while wr_en = 1.
- wr_en  out  1  one-cycle register file write strobe.
- done  out  1  one-cycle completion pulse, coincident with wr_en.
- busy  out  1  high in COLLECT and WRITE.
- err  out  1  sticky error flag; cleared by start or reset.

Behaviour:
- FSM states: IDLE, COLLECT, WRITE.
- Reset: state = IDLE; buf, vd_out, wr_en, done, busy, err all 0. Reset applied mid-operation abandons the operation with no write.
- IDLE + start: buf <= vd_old; capture mask_in, instr_mask, vsew, vl; err <= 0; go to COLLECT. Lane inputs are ignored in IDLE.
- COLLECT, each cycle, for each lane i with lane_valid[i] = 1:
  - idx = lane_index[i]; elem = idx >> (vsew+3).
  - Out of range (idx + W > VLEN, or idx not a multiple of W): slice dropped, err <= 1.
  - Tail (elem >= vl): slice dropped, no error.
  - Masked off (instr_mask && !mask[elem]): slice dropped, no error.
  - Otherwise buf[idx +: W] <= lane_vd[64i +: W].
- Same-cycle collision: if two lanes target the same idx, the highest-numbered lane wins.
- COLLECT + alu_done: slices valid in that same cycle are still accepted; go to WRITE.
- WRITE (exactly one cycle): vd_out = buf, wr_en = 1, done = 1; next state IDLE.
  - Latency: wr_en rises one cycle after the cycle in which alu_done is sampled.
- vd_out holds its last value outside WRITE; consumers sample it only while wr_en = 1.
- start while busy: ignored. start in the cycle after WRITE: accepted normally.
- alu_done in IDLE: ignored.
- SEW > W: an element spans several slices; every slice of one element uses the same mask bit and tail decision.
- busy = (state != IDLE).

Optional Feature:
- Macro: RVV_VD_COLLECT_CHK_EN.
- Defined: keep a written bitmap of VLEN/W bits, cleared at start.
  - A slice accepted into a slice position already written in this operation sets err.
  - A same-cycle lane collision also sets err.
  - Data behaviour is unchanged: the last writer wins.
- Undefined: no bitmap; err reflects out-of-range slices only.

Test Plan:
- Configuration for all scenarios: VLEN=128, LANE_WIDTH=3, NB_LANES=1.
- Unmasked: vsew=0, vl=16, vd_old=0; cycle 1 lanes (idx 0, 0x11) and (idx 8, 0x22); cycle 2 (idx 16, 0x33) with alu_done -> next cycle wr_en=done=1, vd_out[23:0]=0x332211, remaining bits 0.
- Masked: instr_mask=1, mask_in=0x5, vd_old=all 0xFF, vsew=0, vl=16; write 0xAA at idx 0, 8, 16, 24 -> vd_out[31:0]=0xFFAAFFAA.
- Tail: vl=2, vsew=0, vd_old=0; write 0x77 at idx 0..24 -> vd_out[31:0]=0x00007777, err=0.
- SEW16 spanning: vsew=1, instr_mask=1, mask_in=0x1, vd_old=0; write 0x34 at idx 0, 0x12 at idx 8, 0x99 at idx 16 -> vd_out[31:0]=0x00001234.
- Errors and reset: idx 128 slice -> dropped, err=1, stays 1 until next start. Separately, reset asserted during COLLECT -> busy=0 next cycle, no wr_en pulse.
- CHK build: idx 8 written twice in separate cycles -> err=1 and vd_out byte 1 holds the second value. Non-CHK build, same stimulus -> err=0.
